// File: rtl/arith_sequencer.sv
// Multi-cycle fetch/decode/writeback controller for the arithmetic datapath.
// Optional single-step mode (PAUSE state and step input) is enabled by defining SINGLE_STEP_EN.
module arith_sequencer #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          TIMEOUT   = 15,
  parameter int unsigned          CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic [PC_WIDTH-3:0]  imem_addr,
  output logic                 ir_load,
  input  logic                 except_in,
  output logic                 rf_we,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 halted,
  output logic                 fault,
  input  logic                 resume,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StWb,
    StHalt
`ifdef SINGLE_STEP_EN
    , StPause
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q;
  logic             timeout_hit;
  logic             halted_d;

  // Last FETCH cycle before giving up; an ack in this same cycle still wins.
  assign timeout_hit = (wait_cnt_q == WaitW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StHalt;
        end
      end
      StDecode: state_d = except_in ? StHalt : StWb;
`ifdef SINGLE_STEP_EN
      StWb:     state_d = StPause;
      StPause:  if (step) state_d = StFetch;
`else
      StWb:     state_d = StFetch;
`endif
      StHalt:   if (resume) state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    halted_d = (state_d == StHalt);
`ifdef SINGLE_STEP_EN
    if (state_d == StPause) halted_d = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc         <= RESET_PC;
      retired    <= '0;
      wait_cnt_q <= '0;
      fault      <= 1'b0;
      imem_req   <= 1'b0;
      rf_we      <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Moore outputs registered from the next state so they track state_q exactly.
      imem_req <= (state_d == StFetch);
      rf_we    <= (state_d == StWb);
      halted   <= halted_d;
      case (state_q)
        StFetch: begin
          if (imem_ack) begin
            wait_cnt_q <= '0;
          end else if (timeout_hit) begin
            wait_cnt_q <= '0;
            fault      <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StWb: begin
          pc      <= pc + PC_WIDTH'(4);
          retired <= retired + CNT_WIDTH'(1);
        end
        StHalt: begin
          if (resume) begin
            // Decoder exceptions skip the offending word; fetch timeouts retry it.
            if (!fault) pc <= pc + PC_WIDTH'(4);
            fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ir_load   = imem_req & imem_ack;
  assign imem_addr = pc[PC_WIDTH-1:2];

endmodule
